// File: rtl/apbgpu_pkg.sv
// Shared GPU command types and word layout; the GPU responder decodes against the same constants.
package apbgpu_pkg;

  typedef logic [3:0]  opcode_t;
  typedef logic [24:0] params_t;

  typedef struct packed {
    opcode_t opcode;
    params_t params;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 28;
  localparam int unsigned PARAM_MSB  = 24;

  // Bits between the opcode and the parameter field are reserved and driven as zero.
  function automatic logic [31:0] pack_cmd(input cmd_t cmd);
    logic [31:0] word;
    word = '0;
    word[OPCODE_MSB:OPCODE_LSB] = cmd.opcode;
    word[PARAM_MSB:0]           = cmd.params;
    return word;
  endfunction

endpackage

// File: rtl/gpu_cmd_fifo.sv
// Synchronous command FIFO; occupancy counter carries one extra bit to tell full from empty.
module gpu_cmd_fifo
  import apbgpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  cmd_t                     push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output cmd_t                     head
);

  localparam int unsigned AW = $clog2(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full    = (count_q == (AW + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign count   = count_q;
  assign head    = mem[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/apb_gpu_cmd_master.sv
// APB write initiator draining a command FIFO into the GPU command responder.
module apb_gpu_cmd_master
  import apbgpu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] GPU_ADDR   = 32'h0000_0000,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmdValid_i,
  output logic                          cmdReady_o,
  input  logic [3:0]                    opcode_i,
  input  logic [24:0]                   parameters_i,
  output logic [31:0]                   pAddr_o,
  output logic [31:0]                   pDataWrite_o,
  output logic                          pSel_o,
  output logic                          pEnable_o,
  output logic                          pWrite_o,
  input  logic                          pReady_i,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount_o,
  output logic [CNT_WIDTH-1:0]          txCount_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  state_t                state_q;
  logic [CNT_WIDTH-1:0]  tx_count_q;
  logic                  full, empty;
  logic [CW-1:0]         count;
  cmd_t                  head;
  cmd_t                  push_data;
  logic                  push_fire, pop_fire, more_after_pop;

  assign cmdReady_o     = ~full & ~rst;
  assign push_fire      = cmdValid_i & cmdReady_o;
  assign pop_fire       = (state_q == ACCESS) & pReady_i;
  // A push landing on the completing edge keeps the FIFO non-empty, so go straight to SETUP.
  assign more_after_pop = (count > CW'(1)) | push_fire;
  assign push_data      = '{opcode: opcode_i, params: parameters_i};

  gpu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_fire),
    .push_data (push_data),
    .pop       (pop_fire),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .head      (head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_count_q <= '0;
    end else begin
      unique case (state_q)
        IDLE:   if (!empty) state_q <= SETUP;
        SETUP:  state_q <= ACCESS;
        ACCESS: begin
          if (pReady_i) begin
            tx_count_q <= tx_count_q + 1'b1;
            state_q    <= more_after_pop ? SETUP : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // FIFO head stays put until the completing ACCESS edge, so data is stable for the whole transfer.
  assign pSel_o       = (state_q != IDLE);
  assign pWrite_o     = pSel_o;
  assign pEnable_o    = (state_q == ACCESS);
  assign pAddr_o      = pSel_o ? GPU_ADDR : '0;
  assign pDataWrite_o = pSel_o ? pack_cmd(head) : '0;
  assign busy_o       = pSel_o | ~empty;
  assign fifoCount_o  = count;
  assign txCount_o    = tx_count_q;

endmodule

// File: tb/tb_apb_gpu_cmd_master.sv
// Scoreboard bench: expected command words queued on accepted pushes, checked at APB completion.
module tb_apb_gpu_cmd_master;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned CNT_WIDTH  = 4;
  localparam logic [31:0] GPU_ADDR   = 32'hA000_0100;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic                        cmdValid = 1'b0;
  logic                        cmdReady;
  logic [3:0]                  opcode = '0;
  logic [24:0]                 parameters = '0;
  logic [31:0]                 pAddr, pDataWrite;
  logic                        pSel, pEnable, pWrite;
  logic                        pReady = 1'b0;
  logic                        busy;
  logic [$clog2(FIFO_DEPTH):0] fifoCount;
  logic [CNT_WIDTH-1:0]        txCount;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_done   = 0;
  logic [31:0] sb [$];
  logic [31:0] sb_word;

  apb_gpu_cmd_master #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .GPU_ADDR   (GPU_ADDR),
    .CNT_WIDTH  (CNT_WIDTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmdValid_i   (cmdValid),
    .cmdReady_o   (cmdReady),
    .opcode_i     (opcode),
    .parameters_i (parameters),
    .pAddr_o      (pAddr),
    .pDataWrite_o (pDataWrite),
    .pSel_o       (pSel),
    .pEnable_o    (pEnable),
    .pWrite_o     (pWrite),
    .pReady_i     (pReady),
    .busy_o       (busy),
    .fifoCount_o  (fifoCount),
    .txCount_o    (txCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: record accepted pushes, compare at each completing ACCESS cycle.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (pSel && pEnable && pReady) begin
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          sb_word = sb.pop_front();
          check("data", pDataWrite, sb_word);
          check("addr", pAddr, GPU_ADDR);
        end
        n_done++;
      end
      if (cmdValid && cmdReady) sb.push_back({opcode, 3'b000, parameters});
    end
  end

  task automatic push_cmd(input logic [3:0] op, input logic [24:0] par);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    opcode     = op;
    parameters = par;
    cmdValid   = 1'b1;
    while (!acc && n < 50) begin
      acc = cmdReady;
      tick();
      n++;
    end
    cmdValid = 1'b0;
    check("push_accepted", 32'(acc), 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [8:0]  sel_v, en_v;
    logic [31:0] d0;
    int          n;

    // Reset state
    #12;
    check("rst_ready", 32'(cmdReady), 32'd0);
    check("rst_psel", 32'(pSel), 32'd0);
    check("rst_fifo", 32'(fifoCount), 32'd0);
    check("rst_tx", 32'(txCount), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(cmdReady), 32'd1);
    tick();

    // Single command, no wait states
    pReady = 1'b1;
    push_cmd(4'hA, 25'h1ABCDE);
    check("t1_still_idle", 32'(pSel), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_count", 32'(fifoCount), 32'd1);
    tick();
    check("t1_setup_sel", 32'(pSel), 32'd1);
    check("t1_setup_en", 32'(pEnable), 32'd0);
    check("t1_setup_wr", 32'(pWrite), 32'd1);
    check("t1_setup_addr", pAddr, GPU_ADDR);
    check("t1_setup_data", pDataWrite, 32'hA01A_BCDE);
    tick();
    check("t1_access_en", 32'(pEnable), 32'd1);
    tick();
    check("t1_idle_sel", 32'(pSel), 32'd0);
    check("t1_idle_data", pDataWrite, 32'd0);
    check("t1_tx", 32'(txCount), 32'd1);
    check("t1_busy_end", 32'(busy), 32'd0);

    // Three back-to-back commands
    for (int i = 0; i < 9; i++) begin
      if (i < 3) begin
        opcode     = 4'(i + 1);
        parameters = 25'(32'h100 + i);
        cmdValid   = 1'b1;
      end else begin
        cmdValid = 1'b0;
      end
      sel_v[i] = pSel;
      en_v[i]  = pEnable;
      tick();
    end
    check("t2_sel_pattern", 32'(sel_v), 32'h0FC);
    check("t2_en_pattern", 32'(en_v), 32'h0A8);
    wait_idle();
    check("t2_tx", 32'(txCount), 32'd4);

    // Two wait states
    pReady = 1'b0;
    push_cmd(4'h5, 25'h0F0F0F);
    n = 0;
    while (!pEnable && n < 10) begin
      tick();
      n++;
    end
    check("t3_access", 32'(pEnable), 32'd1);
    d0 = pDataWrite;
    tick();
    check("t3_wait1_en", 32'(pEnable), 32'd1);
    check("t3_wait1_data", pDataWrite, d0);
    tick();
    check("t3_wait2_en", 32'(pEnable), 32'd1);
    check("t3_wait2_data", pDataWrite, d0);
    check("t3_wait_count", 32'(fifoCount), 32'd1);
    pReady = 1'b1;
    tick();
    check("t3_done_en", 32'(pEnable), 32'd0);
    check("t3_tx", 32'(txCount), 32'd5);
    check("t3_count", 32'(fifoCount), 32'd0);
    pReady = 1'b0;

    // Overfill: fifth push stalls until the first pop
    for (int i = 0; i < 4; i++) push_cmd(4'(8 + i), 25'(32'h1000 * (i + 1)));
    check("t4_full_count", 32'(fifoCount), 32'd4);
    check("t4_full_ready", 32'(cmdReady), 32'd0);
    opcode     = 4'hF;
    parameters = 25'h1FFFFFF;
    cmdValid   = 1'b1;
    tick();
    tick();
    check("t4_no_push_full", 32'(fifoCount), 32'd4);
    pReady = 1'b1;
    tick();
    check("t4_after_pop", 32'(fifoCount), 32'd3);
    check("t4_ready_again", 32'(cmdReady), 32'd1);
    tick();
    check("t4_fifth_in", 32'(fifoCount), 32'd4);
    cmdValid = 1'b0;
    wait_idle();
    check("t4_tx", 32'(txCount), 32'd10);

    // Reset during ACCESS with two commands queued
    pReady = 1'b0;
    for (int i = 0; i < 3; i++) push_cmd(4'(2 + i), 25'(32'h77 + i));
    n = 0;
    while (!pEnable && n < 10) begin
      tick();
      n++;
    end
    check("t5_in_access", 32'(pEnable), 32'd1);
    rst = 1'b1;
    #1;
    check("t5_sel", 32'(pSel), 32'd0);
    check("t5_en", 32'(pEnable), 32'd0);
    check("t5_count", 32'(fifoCount), 32'd0);
    check("t5_tx", 32'(txCount), 32'd0);
    check("t5_ready", 32'(cmdReady), 32'd0);
    tick();
    rst    = 1'b0;
    pReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_quiet_sel", 32'(pSel), 32'd0);
    end
    check("t5_quiet_tx", 32'(txCount), 32'd0);

    // Counter wrap with a 4-bit counter
    n = int'(n_done);
    for (int i = 0; i < 15; i++) push_cmd(4'(i), 25'($urandom));
    wait_idle();
    check("t6_tx_15", 32'(txCount), 32'd15);
    push_cmd(4'h3, 25'($urandom));
    wait_idle();
    check("t6_tx_wrap", 32'(txCount), 32'd0);
    check("t6_done", 32'(n_done - n), 32'd16);
    check("t6_sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
